calendar_counter: RTL and testbench
===================================

Name: calendar_counter

Overview:
- Sequential time/date core of the calendar design: counts seconds, minutes, hours, day, month and year in binary.
- Handles month lengths and leap years (years 2000–2099).
- Each 8-bit binary field is the direct upstream feed of one binary-to-BCD converter per displayed field.
- Includes a clock prescaler for the 1 Hz tick and a validated set interface for loading a date/time.

Parameters:
- CLK_DIV, 50_000_000, clk cycles per second tick; legal range ≥2.
- FAST_SIM, 0, when 1 the prescaler is bypassed and every enabled clk cycle is a tick (bench only).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- run  in  1  1 = time advances; 0 = frozen, prescaler holds its count.
- set_valid  in  1  one-cycle request to load set_* fields.
- set_sec  in  8  0–59.
- set_min  in  8  0–59.
- set_hour  in  8  0–23.
- set_day  in  8  1–days_in_month.
- set_month  in  8  1–12.
- set_year  in  8  0–99, meaning 2000+value.
- sec  out  8  current second, binary.
- min  out  8  current minute, binary.
- hour  out  8  current hour, binary.
- day  out  8  current day, binary.
- month  out  8  current month, binary.
- year  out  8  current year, binary.
- sec_tick  out  1  one-cycle pulse on every applied second increment.
- day_roll  out  1  one-cycle pulse when the date advances at 23:59:59→00:00:00.
- set_err  out  1  one-cycle pulse when a set request is rejected.

Behaviour:
- Reset (async assert, sync release):
  - sec=min=hour=0, day=1, month=1, year=0.
  - Prescaler count=0.
  - All pulse outputs 0.
- Prescaler:
  - Counts 0..CLK_DIV-1 while run=1 and wraps at CLK_DIV-1.
  - The internal tick is asserted in the wrap cycle.
  - With run=0 the count holds and no tick is produced.
- Second increment on tick, all fields updated in the same clk edge (single-cycle cascade):
  - sec 59→0 carries to min.
  - min 59→0 carries to hour.
  - hour 23→0 carries to day.
  - day == days_in_month(month, year) → day=1, carries to month.
  - month 12→1 carries to year.
  - year 99→0 (wrap, no error).
- Outputs are registered. sec_tick and day_roll assert in the cycle after the edge that updated the fields, aligned with the new values.
- days_in_month:
  - 31 for months 1, 3, 5, 7, 8, 10, 12.
  - 30 for months 4, 6, 9, 11.
  - Feb = 29 if year[1:0]==0, else 28. Year 0 (2000) is a leap year.
- Set request (set_valid=1), checked combinationally the same cycle:
  - Valid: every field is in range, using the requested month/year for the day bound. All six fields are loaded on that edge, the prescaler is cleared to 0, and no sec_tick is produced that cycle.
  - Invalid: the registers are unchanged, set_err pulses for one cycle, and the prescaler is unaffected.
- Simultaneous set_valid and tick:
  - A valid set wins; the tick is discarded.
  - An invalid set does not suppress the tick; the time advances normally and set_err pulses.
- set_valid is accepted regardless of run.
- No ready signal: every set request is consumed in one cycle.
- Reset mid-operation clears everything immediately; a pending set is lost.
- Out-of-range state is unreachable. Even so, the cascade compares with ≥ rather than ==, so corrupted values recover on the next tick.

Decomposition:
- calendar_pkg, shared with the display path, holds:
  - the field width constant (8);
  - the limits SEC_MAX=59, MIN_MAX=59, HOUR_MAX=23, MONTH_MAX=12, YEAR_MAX=99;
  - the pure function days_in_month(month, year);
  - the function date_valid(...).
- Sub-module cal_prescaler (params CLK_DIV, FAST_SIM; ports clk, rst_n, run, clr, tick).
- Everything else (cascade, set checking, output registers) lives in calendar_counter.

Test Plan:
- Reset: assert rst_n=0 mid-count, release → fields read 0:0:0, 1/1/0, pulses 0; with FAST_SIM=0 and CLK_DIV=4, the first sec_tick arrives 4 cycles after release with run=1.
- Full cascade: set 23:59:59, 31/12/99, one tick → 0:0:0, 1/1/0, day_roll=1 and sec_tick=1 for exactly one cycle.
- Leap year: set 23:59:59, 28/2/4, tick → 29/2/4; tick 86400 more (FAST_SIM) → 1/3/4. Set 28/2/5 at 23:59:59, tick → 1/3/5.
- 30-day month: set 23:59:59, 30/4/10, tick → 1/5/10; set day=31, month=4 → set_err pulse, fields unchanged.
- Set validation: set_hour=24 or set_month=0 → set_err=1 one cycle, no change; set 12:34:56, 15/6/24 → fields loaded next cycle, prescaler restarts (next tick exactly CLK_DIV cycles later).
- Collisions and freeze: valid set in the tick cycle → loaded values visible, no increment, no sec_tick. run=0 for 10 cycles → fields and prescaler frozen, resume continues from the held count.

Source files
------------

// File: rtl/calendar_pkg.sv
// Shared calendar constants and date helpers, used by the counter core and the display path.
package calendar_pkg;

    localparam int unsigned FIELD_W = 8;

    localparam logic [FIELD_W-1:0] SEC_MAX   = 8'd59;
    localparam logic [FIELD_W-1:0] MIN_MAX   = 8'd59;
    localparam logic [FIELD_W-1:0] HOUR_MAX  = 8'd23;
    localparam logic [FIELD_W-1:0] MONTH_MAX = 8'd12;
    localparam logic [FIELD_W-1:0] YEAR_MAX  = 8'd99;

    // Years are offsets from 2000, so every multiple of four is a leap year.
    function automatic logic [FIELD_W-1:0] days_in_month(
        input logic [FIELD_W-1:0] month,
        input logic [FIELD_W-1:0] year
    );
        logic [FIELD_W-1:0] dim;
        unique case (month)
            8'd4, 8'd6, 8'd9, 8'd11: dim = 8'd30;
            8'd2:                    dim = (year[1:0] == 2'b00) ? 8'd29 : 8'd28;
            default:                 dim = 8'd31;
        endcase
        return dim;
    endfunction

    function automatic logic date_valid(
        input logic [FIELD_W-1:0] sec,
        input logic [FIELD_W-1:0] min,
        input logic [FIELD_W-1:0] hour,
        input logic [FIELD_W-1:0] day,
        input logic [FIELD_W-1:0] month,
        input logic [FIELD_W-1:0] year
    );
        return (sec <= SEC_MAX) && (min <= MIN_MAX) && (hour <= HOUR_MAX) &&
               (month >= 8'd1) && (month <= MONTH_MAX) && (year <= YEAR_MAX) &&
               (day >= 8'd1) && (day <= days_in_month(month, year));
    endfunction

endpackage

// File: rtl/cal_prescaler.sv
// Divides clk down to a one-cycle tick every CLK_DIV enabled cycles.
module cal_prescaler #(
    parameter int unsigned CLK_DIV  = 50_000_000,
    parameter bit          FAST_SIM = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic run,
    input  logic clr,
    output logic tick
);

    localparam int unsigned   CW   = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

    logic [CW-1:0] count_q, count_d;
    logic          wrap;

    assign wrap = (count_q >= LAST);
    // Counter keeps running under FAST_SIM so both builds share one datapath.
    assign tick = run && (FAST_SIM ? 1'b1 : wrap);

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (run) begin
            count_d = wrap ? '0 : count_q + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/calendar_counter.sv
// Binary time/date counter with 1 Hz prescaler, leap-year aware cascade and validated set port.
module calendar_counter
    import calendar_pkg::*;
#(
    parameter int unsigned CLK_DIV  = 50_000_000,
    parameter bit          FAST_SIM = 1'b0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               run,
    input  logic               set_valid,
    input  logic [FIELD_W-1:0] set_sec,
    input  logic [FIELD_W-1:0] set_min,
    input  logic [FIELD_W-1:0] set_hour,
    input  logic [FIELD_W-1:0] set_day,
    input  logic [FIELD_W-1:0] set_month,
    input  logic [FIELD_W-1:0] set_year,
    output logic [FIELD_W-1:0] sec,
    output logic [FIELD_W-1:0] min,
    output logic [FIELD_W-1:0] hour,
    output logic [FIELD_W-1:0] day,
    output logic [FIELD_W-1:0] month,
    output logic [FIELD_W-1:0] year,
    output logic               sec_tick,
    output logic               day_roll,
    output logic               set_err
);

    logic [FIELD_W-1:0] sec_q, sec_d, min_q, min_d, hour_q, hour_d;
    logic [FIELD_W-1:0] day_q, day_d, month_q, month_d, year_q, year_d;
    logic               sec_tick_q, sec_tick_d, day_roll_q, day_roll_d, set_err_q, set_err_d;

    logic tick, set_ok, adv;
    logic sec_wrap, min_wrap, hour_wrap, day_wrap, month_wrap, year_wrap;

    assign set_ok = set_valid &&
                    date_valid(set_sec, set_min, set_hour, set_day, set_month, set_year);
    // A valid set wins over a coincident tick; an invalid one lets it through.
    assign adv    = tick && !set_ok;

    cal_prescaler #(
        .CLK_DIV  (CLK_DIV),
        .FAST_SIM (FAST_SIM)
    ) u_prescaler (
        .clk   (clk),
        .rst_n (rst_n),
        .run   (run),
        .clr   (set_ok),
        .tick  (tick)
    );

    // >= rather than == so a corrupted field snaps back on the next tick.
    assign sec_wrap   = (sec_q >= SEC_MAX);
    assign min_wrap   = (min_q >= MIN_MAX);
    assign hour_wrap  = (hour_q >= HOUR_MAX);
    assign day_wrap   = (day_q >= days_in_month(month_q, year_q));
    assign month_wrap = (month_q >= MONTH_MAX);
    assign year_wrap  = (year_q >= YEAR_MAX);

    always_comb begin
        sec_d      = sec_q;
        min_d      = min_q;
        hour_d     = hour_q;
        day_d      = day_q;
        month_d    = month_q;
        year_d     = year_q;
        sec_tick_d = adv;
        day_roll_d = adv && sec_wrap && min_wrap && hour_wrap;
        set_err_d  = set_valid && !set_ok;

        if (set_ok) begin
            sec_d   = set_sec;
            min_d   = set_min;
            hour_d  = set_hour;
            day_d   = set_day;
            month_d = set_month;
            year_d  = set_year;
        end else if (adv) begin
            sec_d = sec_wrap ? '0 : sec_q + 8'd1;
            if (sec_wrap) begin
                min_d = min_wrap ? '0 : min_q + 8'd1;
                if (min_wrap) begin
                    hour_d = hour_wrap ? '0 : hour_q + 8'd1;
                    if (hour_wrap) begin
                        day_d = day_wrap ? 8'd1 : day_q + 8'd1;
                        if (day_wrap) begin
                            month_d = month_wrap ? 8'd1 : month_q + 8'd1;
                            if (month_wrap) begin
                                year_d = year_wrap ? '0 : year_q + 8'd1;
                            end
                        end
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sec_q      <= '0;
            min_q      <= '0;
            hour_q     <= '0;
            day_q      <= 8'd1;
            month_q    <= 8'd1;
            year_q     <= '0;
            sec_tick_q <= 1'b0;
            day_roll_q <= 1'b0;
            set_err_q  <= 1'b0;
        end else begin
            sec_q      <= sec_d;
            min_q      <= min_d;
            hour_q     <= hour_d;
            day_q      <= day_d;
            month_q    <= month_d;
            year_q     <= year_d;
            sec_tick_q <= sec_tick_d;
            day_roll_q <= day_roll_d;
            set_err_q  <= set_err_d;
        end
    end

    assign sec      = sec_q;
    assign min      = min_q;
    assign hour     = hour_q;
    assign day      = day_q;
    assign month    = month_q;
    assign year     = year_q;
    assign sec_tick = sec_tick_q;
    assign day_roll = day_roll_q;
    assign set_err  = set_err_q;

endmodule

// File: tb/tb_calendar_counter.sv
// Scoreboard bench: driver pushes model predictions per cycle, monitor pops and compares.
module tb_calendar_counter;

    localparam int unsigned DIV = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       run = 1'b0;
    logic       set_valid = 1'b0;
    logic [7:0] set_sec = '0, set_min = '0, set_hour = '0;
    logic [7:0] set_day = '0, set_month = '0, set_year = '0;
    logic [7:0] sec, min, hour, day, month, year;
    logic       sec_tick, day_roll, set_err;

    calendar_counter #(
        .CLK_DIV  (DIV),
        .FAST_SIM (1'b0)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .run       (run),
        .set_valid (set_valid),
        .set_sec   (set_sec),
        .set_min   (set_min),
        .set_hour  (set_hour),
        .set_day   (set_day),
        .set_month (set_month),
        .set_year  (set_year),
        .sec       (sec),
        .min       (min),
        .hour      (hour),
        .day       (day),
        .month     (month),
        .year      (year),
        .sec_tick  (sec_tick),
        .day_roll  (day_roll),
        .set_err   (set_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] sec, min, hour, day, month, year;
        logic       st, dr, se;
    } obs_t;

    obs_t  exp_q[$];
    string tag_q[$];
    int    total = 0;
    int    bad = 0;

    // Reference model: time of day in seconds plus calendar date.
    int m_tod, m_day, m_month, m_year, m_cnt;
    bit m_st, m_dr, m_se;

    function automatic int dim(input int mo, input int y);
        int len[12] = '{31, 28, 31, 30, 31, 30, 31, 31, 30, 31, 30, 31};
        if (mo < 1 || mo > 12) return 31;
        if (mo == 2 && (y % 4) == 0) return 29;
        return len[mo-1];
    endfunction

    function automatic bit ok_date(input int s, mi, h, d, mo, y);
        return s < 60 && mi < 60 && h < 24 && mo >= 1 && mo <= 12 && y < 100 &&
               d >= 1 && d <= dim(mo, y);
    endfunction

    function automatic obs_t model_obs();
        obs_t o;
        o.sec   = 8'(m_tod % 60);
        o.min   = 8'((m_tod / 60) % 60);
        o.hour  = 8'(m_tod / 3600);
        o.day   = 8'(m_day);
        o.month = 8'(m_month);
        o.year  = 8'(m_year);
        o.st    = m_st;
        o.dr    = m_dr;
        o.se    = m_se;
        return o;
    endfunction

    task automatic model_reset();
        m_tod = 0; m_day = 1; m_month = 1; m_year = 0; m_cnt = 0;
        m_st = 0; m_dr = 0; m_se = 0;
    endtask

    task automatic model_step(input bit r, input bit sv, input int s, mi, h, d, mo, y);
        bit tk, ok;
        tk = r && (m_cnt == DIV - 1);
        ok = sv && ok_date(s, mi, h, d, mo, y);
        m_st = 0; m_dr = 0; m_se = sv && !ok;
        if (ok) begin
            m_tod = h * 3600 + mi * 60 + s;
            m_day = d; m_month = mo; m_year = y; m_cnt = 0;
        end else begin
            if (r) m_cnt = (m_cnt + 1) % DIV;
            if (tk) begin
                m_st = 1;
                m_tod = m_tod + 1;
                if (m_tod == 86400) begin
                    m_tod = 0;
                    m_dr = 1;
                    m_day = m_day + 1;
                    if (m_day > dim(m_month, m_year)) begin
                        m_day = 1;
                        m_month = m_month + 1;
                        if (m_month > 12) begin
                            m_month = 1;
                            m_year = (m_year + 1) % 100;
                        end
                    end
                end
            end
        end
    endtask

    task automatic cyc(input bit r, input bit sv, input int s, mi, h, d, mo, y,
                       input string tag);
        @(negedge clk);
        run = r; set_valid = sv;
        set_sec = 8'(s); set_min = 8'(mi); set_hour = 8'(h);
        set_day = 8'(d); set_month = 8'(mo); set_year = 8'(y);
        model_step(r, sv, s, mi, h, d, mo, y);
        exp_q.push_back(model_obs());
        tag_q.push_back(tag);
    endtask

    task automatic idle(input int n, input bit r, input string tag);
        for (int i = 0; i < n; i++) cyc(r, 1'b0, 0, 0, 0, 0, 0, 0, tag);
    endtask

    task automatic setc(input int s, mi, h, d, mo, y, input string tag);
        cyc(1'b0, 1'b1, s, mi, h, d, mo, y, tag);
    endtask

    task automatic do_reset(input string tag);
        obs_t got, e;
        @(negedge clk);
        rst_n = 1'b0; run = 1'b0; set_valid = 1'b0;
        model_reset();
        #1;
        got = {sec, min, hour, day, month, year, sec_tick, day_roll, set_err};
        e = model_obs();
        total++;
        if (got !== e) begin
            bad++;
            $display("FAIL %s_async got=%h want=%h", tag, got, e);
        end
        exp_q.push_back(e);
        tag_q.push_back(tag);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    always @(posedge clk) begin
        obs_t got, e;
        string t;
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            got = {sec, min, hour, day, month, year, sec_tick, day_roll, set_err};
            total++;
            if (got !== e) begin
                bad++;
                $display("FAIL %s got=%0d:%0d:%0d %0d/%0d/%0d st=%0b dr=%0b se=%0b want=%0d:%0d:%0d %0d/%0d/%0d st=%0b dr=%0b se=%0b",
                         t, got.hour, got.min, got.sec, got.day, got.month, got.year,
                         got.st, got.dr, got.se, e.hour, e.min, e.sec, e.day, e.month,
                         e.year, e.st, e.dr, e.se);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        do_reset("reset");
        idle(6, 1'b1, "first_tick");
        do_reset("reset_midcount");
        idle(5, 1'b1, "after_reset");

        setc(59, 59, 23, 31, 12, 99, "set_eoy");
        idle(5, 1'b1, "full_cascade");

        setc(59, 59, 23, 28, 2, 4, "set_feb28_leap");
        idle(4, 1'b1, "to_feb29");
        setc(59, 59, 23, 29, 2, 4, "set_feb29");
        idle(4, 1'b1, "to_mar1_leap");
        setc(59, 59, 23, 28, 2, 5, "set_feb28");
        idle(4, 1'b1, "to_mar1");

        setc(59, 59, 23, 30, 4, 10, "set_apr30");
        idle(4, 1'b1, "to_may1");
        setc(0, 0, 0, 31, 4, 10, "bad_apr31");
        setc(0, 0, 24, 1, 1, 1, "bad_hour");
        setc(0, 0, 0, 1, 0, 1, "bad_month0");
        setc(60, 0, 0, 1, 1, 1, "bad_sec");
        setc(0, 0, 0, 29, 2, 5, "bad_feb29");
        setc(0, 0, 0, 0, 1, 1, "bad_day0");
        setc(0, 0, 0, 1, 1, 100, "bad_year");
        idle(1, 1'b0, "err_clear");
        setc(56, 34, 12, 15, 6, 24, "set_valid");
        idle(5, 1'b1, "prescaler_restart");

        // Collisions: land set requests on the wrap cycle.
        idle(2, 1'b1, "pre_collide");
        cyc(1'b1, 1'b1, 10, 20, 5, 3, 3, 30, "set_vs_tick");
        idle(3, 1'b1, "pre_collide2");
        cyc(1'b1, 1'b1, 0, 0, 25, 3, 3, 30, "bad_set_vs_tick");
        idle(2, 1'b1, "count_mid");
        idle(10, 1'b0, "frozen");
        idle(6, 1'b1, "resume");

        for (int i = 0; i < 2500; i++) begin
            bit r;
            r = ($urandom % 8) != 0;
            if ($urandom % 12 == 0) begin
                cyc(r, 1'b1, $urandom_range(55, 60), $urandom_range(58, 60),
                    $urandom_range(22, 24), $urandom_range(0, 32), $urandom_range(0, 13),
                    ($urandom % 2) ? $urandom_range(96, 100) : $urandom_range(0, 5), "rand_set");
            end else begin
                cyc(r, 1'b0, 0, 0, 0, 0, 0, 0, "rand_run");
            end
        end

        repeat (3) @(negedge clk);
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain got=%0d want=0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
